// File: rtl/rs232c_pkg.sv
// Shared constants, state encoding and baud helper for the rs232c serial blocks.
// The transmitter, the receiver and the benches all use these.
package rs232c_pkg;

  localparam int DEFAULT_CLOCK    = 50_000_000;
  localparam int DEFAULT_BAUDRATE = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Whole system clocks per line bit; any fractional part is dropped.
  function automatic int calc_cpb(input int clock, input int baudrate);
    return clock / baudrate;
  endfunction

endpackage

// File: rtl/rs232c_sync.sv
// Two-flop synchronizer for an asynchronous input. RESET_VAL is the level the
// flops take in reset; it should match the input's idle level.
module rs232c_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232c_rx.sv
// 8N1 UART receiver. It samples each bit at its centre and outputs the received
// byte with a one-cycle valid pulse. A low stop bit gives a one-cycle frame_err pulse.
module rs232c_rx
  import rs232c_pkg::*;
#(
  parameter int CLOCK    = DEFAULT_CLOCK,
  parameter int BAUDRATE = DEFAULT_BAUDRATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB  = calc_cpb(CLOCK, BAUDRATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  if (CPB < 4) begin : g_cpb_check
    $error("rs232c_rx: CLOCK/BAUDRATE must be at least 4");
  end

  rx_state_t     state;
  rx_state_t     state_next;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          half_hit;
  logic          bit_end;

  rs232c_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign half_hit = (cnt == CW'(HALF - 1));
  assign bit_end  = (cnt == CW'(CPB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The FSM leaves STOP at the centre of the stop bit, so a start edge that
  // follows the stop bit directly is still detected.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (half_hit) state_next = rx_s ? IDLE : DATA;
      DATA:    if (bit_end && idx == 3'd7) state_next = STOP;
      STOP:    if (bit_end) state_next = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        START: begin
          idx <= '0;
          cnt <= half_hit ? '0 : cnt + CW'(1);
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    if (state != IDLE) busy = 1'b1;
  end

endmodule

// File: doc/rs232c_rx.md
Name: rs232c_rx

Overview:
- UART receiver; the downstream stage of the rs232c transmitter. Consumes the serial `tx` line as `rx`.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) at a fixed baud rate and presents each received byte with a one-cycle valid strobe.
- Flags framing errors. Used in benches as a checker and on-chip for loopback.

Parameters:
- CLOCK, 50_000_000, system clock frequency in Hz.
- BAUDRATE, 9600, line bit rate.
- CPB (derived, localparam), CLOCK/BAUDRATE, clocks per bit; elaboration error if < 4.
- HALF (derived, localparam), CPB/2, clocks from start detection to the start-bit centre sample.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- data  out  8  last correctly received byte.
- valid  out  1  one-cycle pulse when `data` updates.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: data=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, synchronizer flops=1, counters=0.
- Reset during a frame aborts it: no valid or frame_err is produced for the partial frame.
- `rx` passes through a 2-FF synchronizer; the synchronized signal is `rx_s`. Pin-to-`rx_s` latency is 2 cycles.
- Counter `cnt` has width $clog2(CPB). Bit index `idx` is 3 bits.
- IDLE:
  - rx_s==0 -> START, cnt<=0.
- START:
  - cnt increments each cycle.
  - At cnt==HALF-1, sample rx_s:
    - 0 -> DATA, cnt<=0, idx<=0.
    - 1 -> IDLE (false start or glitch; no outputs).
- DATA:
  - At cnt==CPB-1: shift rx_s into shreg MSB (right shift, so LSB-first arrival ends with bit0 at shreg[0]); cnt<=0.
  - idx==7 -> STOP, else idx++.
- STOP:
  - At cnt==CPB-1, sample rx_s:
    - 1 -> data<=shreg, valid<=1 for exactly one cycle, -> IDLE.
    - 0 -> frame_err<=1 for one cycle, data unchanged, -> BREAK.
- BREAK:
  - Waits until rx_s==1, then -> IDLE.
  - A line held low (break) yields exactly one frame_err.
- Sample timing: measured from the IDLE cycle in which rx_s is first seen low (t=0):
  - start check at t≈HALF;
  - data bit k sampled at t≈HALF+(k+1)*CPB;
  - stop bit sampled at t≈HALF+9*CPB;
  - valid asserted the following cycle.
- Back-to-back frames: return to IDLE at mid stop bit, so a start edge immediately after the stop bit is caught. No idle gap is required.
- Tolerance: sampling at bit centre tolerates ±4% combined baud mismatch.
- valid and frame_err are never high in the same cycle.
- Outputs are registered; no combinational path from rx to any output.

Decomposition:
- Package rs232c_pkg:
  - default CLOCK and BAUDRATE constants shared with the transmitter and the bench;
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - function computing CPB.
- Sub-module rs232c_sync: 2-FF synchronizer with parameterized reset value (1 here). Reused for other async inputs.

Test Plan:
All cases use CLOCK=16, BAUDRATE=1 (CPB=16, HALF=8); bench drives rx with 16-cycle bits.
- Single frame 0x55, then idle high -> one valid pulse with data=8'h55; frame_err never high; busy falls after the stop sample.
- Back-to-back frames 0xA5, 0x3C, 0xFF with no idle gap -> three valid pulses, data 8'hA5, 8'h3C, 8'hFF in order, spaced 160 cycles apart.
- rx glitch low for 3 cycles while idle -> returns to IDLE after the START check; no valid, no frame_err; data holds previous value.
- Frame 0x81 with stop bit driven low, then line held low for 400 cycles, then high -> exactly one frame_err pulse, no valid, data unchanged; then frame 0x12 -> valid with data=8'h12.
- rst asserted for 5 cycles during data bit 4 of frame 0xC3, released with rx high -> all outputs at reset values, no valid for the aborted frame; next frame 0x5A -> valid with data=8'h5A.
- Loopback with the default-parameter transmitter (50 MHz, 9600 baud) -> every transmitted byte is received with a matching valid and no frame_err.
